// File: rtl/pending_request_scheduler_priority_encoder.sv
// Lowest-set-bit priority encoder: bit 0 has the highest priority.
// Purely combinational. o_valid is low and o_out is zero when no input bit is set.
module priority_encoder #(
  parameter int IW = 4
) (
  input  logic [IW-1:0]         i_in,
  output logic [$clog2(IW)-1:0] o_out,
  output logic                  o_valid
);

  localparam int IDXW = $clog2(IW);

  // Scan from the top bit down, so the lowest set bit is the last one written and wins.
  always_comb begin
    o_out   = '0;
    o_valid = 1'b0;
    for (int i = IW - 1; i >= 0; i--) begin
      if (i_in[i]) begin
        o_out   = IDXW'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pending_request_scheduler.sv
// Sticky request collector: latches one-cycle request pulses and issues each one once.
// Issue order is lowest index first, through a registered valid/ready output stage.
module pending_request_scheduler #(
  parameter int IW = 4
) (
  input  logic                  i_clock,
  input  logic                  i_aresetn,
  input  logic                  i_flush,
  input  logic [IW-1:0]         i_req,
  output logic [$clog2(IW)-1:0] o_idx,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [IW-1:0]         o_pending,
  output logic                  o_busy
);

  localparam int IDXW = $clog2(IW);

  logic [IW-1:0]   pending_q, pending_d;
  logic [IW-1:0]   issueMask;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] selIdx;
  logic            valid_q, valid_d;
  logic            selValid;
  logic            load;

  priority_encoder #(
    .IW (IW)
  ) u_prio (
    .i_in    (pending_q),
    .o_out   (selIdx),
    .o_valid (selValid)
  );

  // The output stage can take a new index when it is empty or is being drained in this cycle.
  assign load      = selValid && (!valid_q || i_ready);
  assign issueMask = load ? (IW'(1) << selIdx) : '0;

  // Flush overrides everything, including requests that arrive in the same cycle.
  always_comb begin
    pending_d = (pending_q & ~issueMask) | i_req;
    valid_d   = valid_q;
    idx_d     = idx_q;
    if (i_flush) begin
      pending_d = '0;
      valid_d   = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      idx_d   = selIdx;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
    end
  end

  assign o_idx     = idx_q;
  assign o_valid   = valid_q;
  assign o_pending = pending_q;
  assign o_busy    = valid_q || (|pending_q);

endmodule
